// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer (00-59) with prescaled step rate, pause/resume,
// a one-cycle expiry pulse and a one-cycle rejected-load pulse.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_ones,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] Q1,
    output logic [3:0] Q2,
    output logic       busy,
    output logic       expired,
    output logic       load_err
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [3:0]    q1_q, q1_d;
    logic [3:0]    q2_q, q2_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          expired_q, expired_d;
    logic          load_err_q, load_err_d;

    logic tick;
    logic count_zero;
    logic preset_ok;
    logic load_accept;
    logic step_to_zero;

    always_comb begin
        state_d     = state_q;
        q1_d        = q1_q;
        q2_d        = q2_q;
        presc_d     = presc_q;
        expired_d   = 1'b0;
        tick        = 1'b0;

        count_zero  = (q1_q == 4'd0) && (q2_q == 4'd0);
        preset_ok   = (preset_tens <= 4'd5) && (preset_ones <= 4'd9);
        load_accept = load && (state_q != S_RUN) && preset_ok;
        load_err_d  = load && ((state_q == S_RUN) || !preset_ok);

        // The prescaler keeps running on the pause edge itself, so the held
        // value reflects every RUN cycle that elapsed.
        if (state_q == S_RUN) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        if (tick) begin
            if (q2_q != 4'd0) begin
                q2_d = q2_q - 4'd1;
            end else begin
                q2_d = 4'd9;
                q1_d = q1_q - 4'd1;
            end
        end

        step_to_zero = tick && (q1_q == 4'd0) && (q2_q == 4'd1);

        if (step_to_zero) begin
            state_d   = S_DONE;
            expired_d = 1'b1;
        end else if (load) begin
            if (load_accept) begin
                q1_d    = preset_tens;
                q2_d    = preset_ones;
                presc_d = '0;
                state_d = S_IDLE;
            end
        end else if (pause) begin
            if (state_q == S_RUN) begin
                state_d = S_PAUSED;
            end
        end else if (start) begin
            if (((state_q == S_IDLE) || (state_q == S_PAUSED)) && !count_zero) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            q1_q       <= 4'd0;
            q2_q       <= 4'd0;
            presc_q    <= '0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q1_q       <= q1_d;
            q2_q       <= q2_d;
            presc_q    <= presc_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    assign Q1       = q1_q;
    assign Q2       = q2_q;
    assign busy     = (state_q == S_RUN);
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule
